// File: rtl/display_mux_monitor.sv
// Reader for a multiplexed 4-digit 7-segment bus: decodes lit digits back to a 16-bit word.
// Optional DISPLAY_MON_CHANGE_ONLY_EN publishes a frame only when its content changes.
module display_mux_monitor #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        frame_err
);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StHold} state_e;

  logic [11:0] sync1, sync2;
  logic [3:0]  an_s, an_low;
  logic [7:0]  sd_s;
  logic        sel_ok;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       snap_an;
  logic [7:0]       snap_sd;
  logic [3:0]       mask;
  logic [15:0]      slot_nib;
  logic [3:0]       slot_dp;
  logic [3:0]       slot_err;

  logic [6:0] dec_in;
  logic [3:0] dec_nib;
  logic       dec_err;
  logic       do_pub;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};
      sync2 <= sync1;
    end
  end

  assign an_s   = sync2[11:8];
  assign sd_s   = sync2[7:0];
  assign an_low = ~an_s;
  assign sel_ok = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);

  // Snapshot segments are active-low with dp in bit 0; decode wants active-high abcdefg.
  assign dec_in = ~snap_sd[7:1];

  always_comb begin
    dec_err = 1'b0;
    dec_nib = 4'h0;
    unique case (dec_in)
      7'h7E: dec_nib = 4'h0;
      7'h30: dec_nib = 4'h1;
      7'h6D: dec_nib = 4'h2;
      7'h79: dec_nib = 4'h3;
      7'h33: dec_nib = 4'h4;
      7'h5B: dec_nib = 4'h5;
      7'h5F: dec_nib = 4'h6;
      7'h70: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h7B: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h1F: dec_nib = 4'hB;
      7'h4E: dec_nib = 4'hC;
      7'h3D: dec_nib = 4'hD;
      7'h4F: dec_nib = 4'hE;
      7'h47: dec_nib = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

`ifdef DISPLAY_MON_CHANGE_ONLY_EN
  logic published_once;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      published_once <= 1'b0;
    end else if (mask == 4'hF) begin
      published_once <= 1'b1;
    end
  end

  assign do_pub = !published_once ||
                  ({slot_nib, slot_dp, |slot_err} != {digits, dp_out, frame_err});
`else
  assign do_pub = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      cnt         <= '0;
      snap_an     <= 4'hF;
      snap_sd     <= 8'hFF;
      mask        <= 4'h0;
      slot_nib    <= 16'h0000;
      slot_dp     <= 4'h0;
      slot_err    <= 4'h0;
      digits      <= 16'h0000;
      dp_out      <= 4'h0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;

      // Mask reaches F only the cycle after the completing capture, so this never
      // coincides with a capture writing mask.
      if (mask == 4'hF) begin
        mask     <= 4'h0;
        slot_err <= 4'h0;
        if (do_pub) begin
          digits      <= slot_nib;
          dp_out      <= slot_dp;
          frame_err   <= |slot_err;
          frame_valid <= 1'b1;
        end
      end

      unique case (state)
        StIdle: begin
          if (sel_ok) begin
            state   <= StSettle;
            cnt     <= CNT_W'(1);
            snap_an <= an_s;
            snap_sd <= sd_s;
          end
        end
        StSettle: begin
          if (!sel_ok) begin
            state <= StIdle;
          end else if (an_s != snap_an || sd_s != snap_sd) begin
            cnt     <= CNT_W'(1);
            snap_an <= an_s;
            snap_sd <= sd_s;
          end else if (cnt == CNT_W'(SETTLE_CYCLES)) begin
            state <= StCapture;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StCapture: begin
          for (int i = 0; i < 4; i++) begin
            if (!snap_an[i]) begin
              slot_nib[4*i +: 4] <= dec_nib;
              slot_dp[i]         <= ~snap_sd[0];
              slot_err[i]        <= dec_err;
              mask[i]            <= 1'b1;
            end
          end
          state <= StHold;
        end
        StHold: begin
          if (an_s != snap_an) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_display_mux_monitor.sv
// Scoreboard bench for display_mux_monitor: scans push expected frames, a monitor pops
// and compares on every frame_valid pulse.
module tb_display_mux_monitor;

  logic        clk, reset;
  logic        an3, an2, an1, an0, a, b, c, d, e, f, g, dp;
  logic [15:0] digits;
  logic [3:0]  dp_out;
  logic        frame_valid, frame_err;

  display_mux_monitor #(.SETTLE_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .digits(digits), .dp_out(dp_out), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic        err;
  } frame_t;

  frame_t exp_q[$];
  frame_t pub;
  logic   pub_valid;
  int     checks = 0;
  int     fails = 0;
  int     frames_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
      4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
      4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
    endcase
  endfunction

  // Expected publication, including change-only suppression when that build is selected.
  task automatic expect_frame(input logic [15:0] dg, input logic [3:0] dpv, input logic err);
    frame_t fr;
    fr = '{dig: dg, dpv: dpv, err: err};
`ifdef DISPLAY_MON_CHANGE_ONLY_EN
    if (!pub_valid || fr != pub) exp_q.push_back(fr);
`else
    exp_q.push_back(fr);
`endif
    pub       = fr;
    pub_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_frame: got digits=0x%0h dp=0x%0h err=%0b, expected none at %0t",
                 digits, dp_out, frame_err, $time);
      end else begin
        frame_t ex;
        ex = exp_q.pop_front();
        chk("frame_digits", 32'(digits), 32'(ex.dig));
        chk("frame_dp_out", 32'(dp_out), 32'(ex.dpv));
        chk("frame_err", 32'(frame_err), 32'(ex.err));
      end
    end
  end

  task automatic drive_pat(input int pos, input logic [6:0] pat, input logic dpon);
    logic [3:0] an_v;
    an_v = ~(4'b0001 << pos);
    {an3, an2, an1, an0} = an_v;
    {a, b, c, d, e, f, g} = ~pat;
    dp = ~dpon;
  endtask

  task automatic show_pat(input int pos, input logic [6:0] pat, input logic dpon, input int n);
    drive_pat(pos, pat, dpon);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [15:0] val, input logic [3:0] dpm);
    for (int p = 3; p >= 0; p--) show_pat(p, hex2seg(val[4*p +: 4]), dpm[p], 32);
  endtask

  task automatic idle_inputs();
    {an3, an2, an1, an0} = 4'hF;
    {a, b, c, d, e, f, g} = 7'h7F;
    dp = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pub_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    idle_inputs();
    pub_valid = 1'b0;
    pub = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_dp_out", 32'(dp_out), 32'h0);
    chk("reset_frame_valid", 32'(frame_valid), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Two back-to-back scans of 1234, one frame each.
    expect_frame(16'h1234, 4'h0, 1'b0);
    scan(16'h1234, 4'h0);
    expect_frame(16'h1234, 4'h0, 1'b0);
    scan(16'h1234, 4'h0);
    chk("t2_pending", 32'(exp_q.size()), 32'h0);

    // Reset asserted mid-settle clears published outputs immediately.
    base = frames_seen;
    drive_pat(1, hex2seg(4'h5), 1'b0);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    pub_valid = 1'b0;
    #1;
    chk("t1_digits", 32'(digits), 32'h0);
    chk("t1_dp_out", 32'(dp_out), 32'h0);
    chk("t1_frame_valid", 32'(frame_valid), 32'h0);
    chk("t1_frame_err", 32'(frame_err), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("t1_no_frame", 32'(frames_seen - base), 32'h0);

    // Glitching segments under an1 must never capture.
    do_reset();
    show_pat(3, hex2seg(4'h9), 1'b0, 32);
    show_pat(2, hex2seg(4'h8), 1'b0, 32);
    show_pat(0, hex2seg(4'h3), 1'b0, 32);
    base = frames_seen;
    for (int i = 0; i < 20; i++) show_pat(1, hex2seg((i % 2 == 0) ? 4'h1 : 4'h7), 1'b0, 3);
    chk("t3_no_frame_glitch", 32'(frames_seen - base), 32'h0);
    expect_frame(16'h9823, 4'h0, 1'b0);
    show_pat(1, hex2seg(4'h2), 1'b0, 32);
    chk("t3_pending", 32'(exp_q.size()), 32'h0);

    // Two anodes low is an invalid select.
    do_reset();
    base = frames_seen;
    {an3, an2, an1, an0} = 4'b0011;
    {a, b, c, d, e, f, g} = ~hex2seg(4'h8);
    dp = 1'b1;
    repeat (50) @(negedge clk);
    chk("t4_no_frame_invalid", 32'(frames_seen - base), 32'h0);
    expect_frame(16'hABCD, 4'h0, 1'b0);
    scan(16'hABCD, 4'h0);
    chk("t4_pending", 32'(exp_q.size()), 32'h0);

    // Undecodable pattern on an2 flags frame_err; a clean scan clears it.
    do_reset();
    expect_frame(16'hF00F, 4'h0, 1'b1);
    show_pat(3, hex2seg(4'hF), 1'b0, 32);
    show_pat(2, 7'b1010101, 1'b0, 32);
    show_pat(1, hex2seg(4'h0), 1'b0, 32);
    show_pat(0, hex2seg(4'hF), 1'b0, 32);
    expect_frame(16'hF00F, 4'h0, 1'b0);
    scan(16'hF00F, 4'h0);
    chk("t5_pending", 32'(exp_q.size()), 32'h0);

    // Repeated identical frames, then a change.
    do_reset();
    base = frames_seen;
    for (int i = 0; i < 3; i++) begin
      expect_frame(16'h5678, 4'b0001, 1'b0);
      scan(16'h5678, 4'b0001);
    end
    expect_frame(16'h5679, 4'b0001, 1'b0);
    scan(16'h5679, 4'b0001);
`ifdef DISPLAY_MON_CHANGE_ONLY_EN
    chk("t6_pulse_count", 32'(frames_seen - base), 32'd2);
`else
    chk("t6_pulse_count", 32'(frames_seen - base), 32'd4);
`endif
    chk("t6_dp_out_level", 32'(dp_out), 32'h1);
    chk("t6_pending", 32'(exp_q.size()), 32'h0);

    idle_inputs();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
